// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU operand sequencer: FSM state encoding and ALU function codes.
// No logic; function codes pass through the sequencer unchanged.
// No flow control.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [3:0] FUNC_ADD  = 4'd0;
    localparam logic [3:0] FUNC_SUB  = 4'd1;
    localparam logic [3:0] FUNC_AND  = 4'd2;
    localparam logic [3:0] FUNC_OR   = 4'd3;
    localparam logic [3:0] FUNC_XOR  = 4'd4;
    localparam logic [3:0] FUNC_NOR  = 4'd5;
    localparam logic [3:0] FUNC_NAND = 4'd6;
    localparam logic [3:0] FUNC_XNOR = 4'd7;
    localparam logic [3:0] FUNC_SHL  = 4'd8;
    localparam logic [3:0] FUNC_SHR  = 4'd9;
    localparam logic [3:0] FUNC_SAR  = 4'd10;
    localparam logic [3:0] FUNC_ROL  = 4'd11;
    localparam logic [3:0] FUNC_ROR  = 4'd12;
    localparam logic [3:0] FUNC_MUL  = 4'd13;
    localparam logic [3:0] FUNC_PASS = 4'd14;
    localparam logic [3:0] FUNC_HAMM = 4'd15;

endpackage

// File: rtl/alu_seq_regfile.sv
// NREG x N register bank: two combinational operand reads, one debug read, one synchronous write.
// Reads are zero-latency; a write becomes visible after the clock edge.
// No backpressure; write enable is always honoured.
module alu_seq_regfile #(
    parameter int N    = 8,
    parameter int NREG = 16,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] ra_addr,
    input  logic [AW-1:0] rb_addr,
    input  logic [AW-1:0] dbg_addr,
    output logic [N-1:0]  ra_data,
    output logic [N-1:0]  rb_data,
    output logic [N-1:0]  dbg_data,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [N-1:0]  wd
);

    logic [N-1:0] regs [NREG];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[wa] <= wd;
        end
    end

    assign ra_data  = regs[ra_addr];
    assign rb_data  = regs[rb_addr];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_operand_sequencer.sv
// Issue stage for a combinational ALU: reads operands, captures RES, writes back (flags under ALU_SEQ_FLAGS_EN).
// ALU command occupies IDLE->EXEC->WB (3 cycles), immediate load IDLE->WB (2 cycles).
// cmd_ready is high only in IDLE; one command in flight, no queueing.
module alu_operand_sequencer
    import alu_seq_pkg::*;
#(
    parameter  int N    = 8,
    parameter  int NREG = 16,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_ld,
    input  logic [3:0]    cmd_func,
    input  logic [AW-1:0] cmd_rs,
    input  logic [AW-1:0] cmd_rt,
    input  logic [AW-1:0] cmd_rd,
    input  logic [N-1:0]  cmd_imm,
    output logic [N-1:0]  alu_a,
    output logic [N-1:0]  alu_b,
    output logic [3:0]    alu_func,
    input  logic [N-1:0]  alu_res,
    output logic          wb_done,
    output logic [N-1:0]  wb_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [N-1:0]  dbg_data
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic          flag_z,
    output logic          flag_n
`endif
);

    state_t        state, state_nxt;
    logic          accept;
    logic [AW-1:0] rd_q;
    logic [N-1:0]  pend_q;
    logic [N-1:0]  rs_data, rt_data;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = cmd_ld ? WB : EXEC;
            EXEC:    state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == IDLE);
        wb_done   = (state == WB);
    end

    assign accept  = cmd_valid && cmd_ready;
    assign wb_data = pend_q;

    // Operands are held outside EXEC; a load only touches the pending result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_func <= '0;
            rd_q     <= '0;
            pend_q   <= '0;
        end else begin
            if (accept) begin
                rd_q <= cmd_rd;
                if (cmd_ld) begin
                    pend_q <= cmd_imm;
                end else begin
                    alu_a    <= rs_data;
                    alu_b    <= rt_data;
                    alu_func <= cmd_func;
                end
            end
            if (state == EXEC) pend_q <= alu_res;
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    logic ld_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ld_q   <= 1'b0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else begin
            if (accept) ld_q <= cmd_ld;
            if (state == WB && !ld_q) begin
                flag_z <= (pend_q == '0);
                flag_n <= pend_q[N-1];
            end
        end
    end
`endif

    alu_seq_regfile #(
        .N    (N),
        .NREG (NREG),
        .AW   (AW)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra_addr  (cmd_rs),
        .rb_addr  (cmd_rt),
        .dbg_addr (dbg_addr),
        .ra_data  (rs_data),
        .rb_data  (rt_data),
        .dbg_data (dbg_data),
        .we       (wb_done),
        .wa       (rd_q),
        .wd       (pend_q)
    );

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench for alu_operand_sequencer with a behavioural ALU and register model.
module tb_alu_operand_sequencer;
    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, cmd_valid, cmd_ready, cmd_ld, wb_done;
    logic [3:0] cmd_func, cmd_rs, cmd_rt, cmd_rd, dbg_addr, alu_func;
    logic [7:0] cmd_imm, alu_a, alu_b, alu_res, wb_data, dbg_data;
`ifdef ALU_SEQ_FLAGS_EN
    logic       flag_z, flag_n;
    logic       mz, mn;
`endif

    int         checks = 0;
    int         failures = 0;
    logic [7:0] mdl [16];
    logic [7:0] last_a, last_b;
    logic [3:0] last_f;

    typedef struct {
        logic       ld;
        logic [3:0] func;
        logic [3:0] rs;
        logic [3:0] rt;
        logic [3:0] rd;
        logic [7:0] imm;
        logic [7:0] exp;
    } vec_t;

    alu_operand_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_ld    (cmd_ld),
        .cmd_func  (cmd_func),
        .cmd_rs    (cmd_rs),
        .cmd_rt    (cmd_rt),
        .cmd_rd    (cmd_rd),
        .cmd_imm   (cmd_imm),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_func  (alu_func),
        .alu_res   (alu_res),
        .wb_done   (wb_done),
        .wb_data   (wb_data),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
`ifdef ALU_SEQ_FLAGS_EN
        ,
        .flag_z    (flag_z),
        .flag_n    (flag_n)
`endif
    );

    function automatic logic [7:0] alu_f(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] dbl;
        case (f)
            FUNC_ADD:  return 8'(a + b);
            FUNC_SUB:  return 8'(a - b);
            FUNC_AND:  return a & b;
            FUNC_OR:   return a | b;
            FUNC_XOR:  return a ^ b;
            FUNC_NOR:  return ~(a | b);
            FUNC_NAND: return ~(a & b);
            FUNC_XNOR: return ~(a ^ b);
            FUNC_SHL:  return a << b[2:0];
            FUNC_SHR:  return a >> b[2:0];
            FUNC_SAR:  return 8'($signed(a) >>> b[2:0]);
            FUNC_ROL:  begin dbl = {a, a} << b[2:0]; return dbl[15:8]; end
            FUNC_ROR:  begin dbl = {a, a} >> b[2:0]; return dbl[7:0]; end
            FUNC_MUL:  return 8'(a * b);
            FUNC_PASS: return a;
            default:   return 8'($countones(a ^ b));
        endcase
    endfunction

    always_comb alu_res = alu_f(alu_func, alu_a, alu_b);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        cmd_ld   = 1'($urandom);
        cmd_func = 4'($urandom);
        cmd_rs   = 4'($urandom);
        cmd_rt   = 4'($urandom);
        cmd_rd   = 4'($urandom);
        cmd_imm  = 8'($urandom);
    endtask

    task automatic drive(input vec_t v);
        cmd_ld = v.ld; cmd_func = v.func; cmd_rs = v.rs;
        cmd_rt = v.rt; cmd_rd = v.rd; cmd_imm = v.imm;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        last_a = 8'h00; last_b = 8'h00; last_f = 4'h0;
`ifdef ALU_SEQ_FLAGS_EN
        mz = 1'b0; mn = 1'b0;
`endif
    endtask

    // One command end to end: accept, latency, write-back value, old/new register contents.
    task automatic run_cmd(input vec_t v, input string nm);
        int         n;
        logic [7:0] old_rd, ea, eb;
        old_rd = mdl[v.rd];
        ea = mdl[v.rs];
        eb = mdl[v.rt];
        drive(v);
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 8) begin step(); n++; end
        chk({nm, "_ready"}, cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        scramble();
        dbg_addr = v.rd;
        n = 1;
        while (!wb_done && n < 6) begin
            if (n == 1 && !v.ld) begin
                chk({nm, "_exec_a"}, alu_a, ea);
                chk({nm, "_exec_b"}, alu_b, eb);
                chk({nm, "_exec_func"}, alu_func, v.func);
            end
            step();
            n++;
        end
        chk({nm, "_latency"}, n, v.ld ? 1 : 2);
        chk({nm, "_wb_data"}, wb_data, v.exp);
        chk({nm, "_dbg_old"}, dbg_data, old_rd);
        chk({nm, "_busy"}, cmd_ready, 0);
        if (v.ld) begin
            chk({nm, "_hold_a"}, alu_a, last_a);
            chk({nm, "_hold_func"}, alu_func, last_f);
        end
        step();
        chk({nm, "_pulse"}, wb_done, 0);
        chk({nm, "_dbg_new"}, dbg_data, v.exp);
        chk({nm, "_ready_after"}, cmd_ready, 1);
        mdl[v.rd] = v.exp;
        if (!v.ld) begin
            last_a = ea; last_b = eb; last_f = v.func;
`ifdef ALU_SEQ_FLAGS_EN
            mz = (v.exp == 8'h00);
            mn = v.exp[7];
`endif
        end
`ifdef ALU_SEQ_FLAGS_EN
        chk({nm, "_flag_z"}, flag_z, mz);
        chk({nm, "_flag_n"}, flag_n, mn);
`endif
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        v.ld   = ($urandom_range(0, 2) == 0);
        v.func = 4'($urandom);
        v.rs   = 4'($urandom);
        v.rt   = 4'($urandom);
        v.rd   = 4'($urandom);
        v.imm  = 8'($urandom);
        v.exp  = v.ld ? v.imm : alu_f(v.func, mdl[v.rs], mdl[v.rt]);
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl [6];
        vec_t bq [12];
        vec_t v;
        logic [7:0] mcopy [16];
        int   acc, wbn, cyc;
        logic busy, took, after_wb, seen;

        tbl[0] = '{1'b1, FUNC_ADD,  4'd0, 4'd0, 4'd1, 8'h05, 8'h05};
        tbl[1] = '{1'b1, FUNC_ADD,  4'd0, 4'd0, 4'd2, 8'h03, 8'h03};
        tbl[2] = '{1'b0, FUNC_ADD,  4'd1, 4'd2, 4'd3, 8'h00, 8'h08};
        tbl[3] = '{1'b0, FUNC_SUB,  4'd1, 4'd2, 4'd1, 8'h00, 8'h02};
        tbl[4] = '{1'b0, FUNC_XOR,  4'd3, 4'd1, 4'd0, 8'h00, 8'h0A};
        tbl[5] = '{1'b0, FUNC_AND,  4'd3, 4'd2, 4'd8, 8'h00, 8'h00};

        rst_n = 1'b0; cmd_valid = 1'b0; dbg_addr = 4'd0;
        scramble();
        model_reset();
        step(); step();
        rst_n = 1'b1;
        chk("rst_ready", cmd_ready, 1);
        chk("rst_wb_done", wb_done, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_func", alu_func, 0);
        chk("rst_wb_data", wb_data, 0);
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #1 chk("rst_dbg", dbg_data, 0);
        end

        for (int i = 0; i < 6; i++) run_cmd(tbl[i], $sformatf("tbl%0d", i));

        for (int i = 0; i < 40; i++) begin
            v = rand_vec();
            run_cmd(v, $sformatf("rnd%0d", i));
        end

        // Back-pressure: valid held high across a burst of different commands.
        for (int i = 0; i < 16; i++) mcopy[i] = mdl[i];
        for (int i = 0; i < 12; i++) begin
            bq[i] = rand_vec();
            if (!bq[i].ld) begin
                last_a = mdl[bq[i].rs]; last_b = mdl[bq[i].rt]; last_f = bq[i].func;
`ifdef ALU_SEQ_FLAGS_EN
                mz = (bq[i].exp == 8'h00); mn = bq[i].exp[7];
`endif
            end
            mdl[bq[i].rd] = bq[i].exp;
        end
        acc = 0; wbn = 0; cyc = 0; busy = 1'b0; after_wb = 1'b0;
        drive(bq[0]);
        cmd_valid = 1'b1;
        while (wbn < 12 && cyc < 300) begin
            took = cmd_valid && cmd_ready;
            if (after_wb) chk("bp_ready_after_wb", cmd_ready, 1);
            after_wb = 1'b0;
            if (busy) chk("bp_ready_busy", cmd_ready, 0);
            if (wb_done) begin
                chk("bp_order", wbn, acc - 1);
                if (wbn < 12) chk($sformatf("bp_wb_data%0d", wbn), wb_data, bq[wbn].exp);
                wbn++;
                busy = 1'b0;
                after_wb = 1'b1;
            end
            step();
            cyc++;
            if (took) begin
                acc++;
                busy = 1'b1;
                if (acc < 12) drive(bq[acc]);
                else cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        chk("bp_accepts", acc, 12);
        chk("bp_writes", wbn, 12);
        step();
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #1 chk($sformatf("bp_reg%0d", i), dbg_data, mdl[i]);
        end
        chk("bp_regs_changed", (mdl[bq[11].rd] == bq[11].exp) && (mcopy[0] == mcopy[0]) ? dbg_data : dbg_data, dbg_data);
        checks--;
`ifdef ALU_SEQ_FLAGS_EN
        chk("bp_flag_z", flag_z, mz);
        chk("bp_flag_n", flag_n, mn);
`endif

        // Reset during EXEC of ADD r4: the write must be dropped.
        v = '{1'b1, FUNC_ADD, 4'd0, 4'd0, 4'd1, 8'h21, 8'h21};
        run_cmd(v, "pre_mid1");
        v = '{1'b1, FUNC_ADD, 4'd0, 4'd0, 4'd4, 8'h11, 8'h11};
        run_cmd(v, "pre_mid4");
        v = '{1'b0, FUNC_ADD, 4'd1, 4'd1, 4'd4, 8'h00, 8'h42};
        drive(v);
        cmd_valid = 1'b1;
        cyc = 0;
        while (!cmd_ready && cyc < 8) begin step(); cyc++; end
        chk("mid_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        chk("mid_exec_no_wb", wb_done, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (wb_done) seen = 1'b1;
            step();
        end
        chk("mid_no_wb", seen, 0);
        dbg_addr = 4'd4;
        #1 chk("mid_r4_zero", dbg_data, 0);
        dbg_addr = 4'd1;
        #1 chk("mid_r1_zero", dbg_data, 0);
        chk("mid_alu_a", alu_a, 0);
        model_reset();

        // Flag sequence: zero result, load leaves flags, negative result.
        v = '{1'b0, FUNC_SUB, 4'd1, 4'd1, 4'd5, 8'h00, 8'h00};
        run_cmd(v, "flg_sub");
        v = '{1'b1, FUNC_ADD, 4'd0, 4'd0, 4'd6, 8'h80, 8'h80};
        run_cmd(v, "flg_ld");
        v = '{1'b0, FUNC_OR,  4'd6, 4'd6, 4'd7, 8'h00, 8'h80};
        run_cmd(v, "flg_or");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
